// File: rtl/apb_sram_arbiter.sv
// apb_sram_arbiter: round-robin APB master that shares one APB slave among N_REQ requesters.
// Each requester posts a single read or write. The winner gets a full SETUP/ACCESS transfer,
// and a one-cycle done pulse returns to it.
// Optional feature: define APB_ARB_TIMEOUT_EN to build an ACCESS-phase PREADY watchdog.
module apb_sram_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned ADDR_BUS_WIDTH = 32,
  parameter int unsigned DATA_BUS_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYC    = 16
) (
  input  logic                            PCLK,
  input  logic                            PRESETn,
  input  logic [N_REQ-1:0]                req_valid,
  input  logic [N_REQ-1:0]                req_write,
  input  logic [N_REQ*ADDR_BUS_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_BUS_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]                rsp_done,
  output logic [DATA_BUS_WIDTH-1:0]       rsp_rdata,
  output logic                            rsp_err,
  output logic                            busy,
  output logic [$clog2(N_REQ)-1:0]        grant_id,
  output logic                            PSEL,
  output logic                            PENABLE,
  output logic                            PWRITE,
  output logic [ADDR_BUS_WIDTH-1:0]       PADDR,
  output logic [DATA_BUS_WIDTH-1:0]       PWDATA,
  input  logic [DATA_BUS_WIDTH-1:0]       PRDATA,
  input  logic                            PREADY,
  input  logic                            PSLVERR
);

  localparam int unsigned IdW = $clog2(N_REQ);
  localparam int unsigned AW  = ADDR_BUS_WIDTH;
  localparam int unsigned DW  = DATA_BUS_WIDTH;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  state_e           state_q, state_d;
  logic [IdW-1:0]   last_q, last_d;
  logic [IdW-1:0]   grant_q, grant_d;
  logic             psel_q, psel_d;
  logic             penable_q, penable_d;
  logic             pwrite_q, pwrite_d;
  logic [AW-1:0]    paddr_q, paddr_d;
  logic [DW-1:0]    pwdata_q, pwdata_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic             pick_valid;
  logic [IdW-1:0]   pick_id;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0]  tmo_q, tmo_d;
`else
  // Without the watchdog the limit has no consumer.
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYC;
`endif

  // Requester index k positions after base, wrapping at N_REQ.
  function automatic logic [IdW-1:0] rr_idx(input logic [IdW-1:0] base, input int unsigned k);
    int unsigned sum;
    sum = 32'(base) + k;
    return IdW'(sum % N_REQ);
  endfunction

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      if (!pick_valid && req_valid[rr_idx(last_q, k)]) begin
        pick_valid = 1'b1;
        pick_id    = rr_idx(last_q, k);
      end
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    done_d    = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    busy_d    = busy_q;
`ifdef APB_ARB_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d  = StSetup;
          grant_d  = pick_id;
          last_d   = pick_id;
          pwrite_d = req_write[pick_id];
          paddr_d  = req_addr[32'(pick_id)*AW +: AW];
          pwdata_d = req_wdata[32'(pick_id)*DW +: DW];
          psel_d   = 1'b1;
          busy_d   = 1'b1;
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
        tmo_d     = '0;
`endif
      end
      StAccess: begin
        if (PREADY) begin
          state_d         = StDone;
          psel_d          = 1'b0;
          penable_d       = 1'b0;
          busy_d          = 1'b0;
          done_d[grant_q] = 1'b1;
          err_d           = PSLVERR;
          if (!pwrite_q) rdata_d = PRDATA;
        end
`ifdef APB_ARB_TIMEOUT_EN
        // PREADY on the final allowed cycle still completes normally.
        else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
          state_d         = StDone;
          psel_d          = 1'b0;
          penable_d       = 1'b0;
          busy_d          = 1'b0;
          done_d[grant_q] = 1'b1;
          err_d           = 1'b1;
          rdata_d         = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      // Turnaround: requests are not sampled so a finishing requester cannot be re-granted.
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer without a done pulse.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      last_q    <= IdW'(N_REQ - 1);
      grant_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign rsp_done  = done_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_sram_arbiter.sv
// tb_apb_sram_arbiter: directed and randomized bench for apb_sram_arbiter.
// A 64-word APB SRAM with programmable wait states acts as the slave. A transaction-level model
// (rotation rule, reference memory, held read data) predicts every grant and completion.
module tb_apb_sram_arbiter;
  localparam int unsigned N       = 4;
  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned MEMSIZE = 64;
  localparam int unsigned TMO     = 16;

  logic          PCLK      = 1'b0;
  logic          PRESETn   = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_write = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]  rsp_done;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, busy;
  logic [1:0]    grant_id;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  apb_sram_arbiter #(
    .N_REQ(N), .ADDR_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW), .TIMEOUT_CYC(TMO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_done(rsp_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .grant_id(grant_id),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // APB SRAM slave: wait_n low-PREADY ACCESS cycles, error outside MEMSIZE, stuck holds PREADY low.
  logic [DW-1:0] mem [MEMSIZE] = '{default: '0};
  int unsigned wait_n = 0, wait_cnt = 0, min_wait = 0, max_wait = 0;
  bit stuck = 1'b0;
  wire in_range = (PADDR < MEMSIZE);
  assign PREADY  = PSEL && PENABLE && !stuck && (wait_cnt >= wait_n);
  assign PRDATA  = in_range ? mem[PADDR[5:0]] : '0;
  assign PSLVERR = PSEL && PENABLE && !in_range;
  always @(posedge PCLK) begin
    wait_cnt <= (PSEL && PENABLE && !PREADY) ? wait_cnt + 1 : 0;
    if (PREADY && PWRITE && in_range) mem[PADDR[5:0]] <= PWDATA;
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [MEMSIZE] = '{default: '0};
  int unsigned   m_last = N - 1;
  logic [DW-1:0] m_rdata = '0;
  bit            in_xfer = 1'b0;
  int unsigned   g = 0, pen_cnt = 0, setup_cnt = 0, n_done = 0;
  bit            g_write;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic [N-1:0]  done_seen = '0;
  int            n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // First pending requester after 'last', wrapping; N when none is pending.
  function automatic int unsigned rr_pick(input int unsigned last, input logic [N-1:0] v);
    for (int unsigned k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return N;
  endfunction

  task automatic post(input int unsigned i, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // One clock: sample 1 time unit after the edge and compare against the model.
  task automatic tick();
    logic [N-1:0] v_before;
    int unsigned  exp_g;
    bit           exp_err;
    v_before = req_valid;
    @(posedge PCLK);
    #1;
    done_seen = rsp_done;
    if (PSEL && !PENABLE) begin
      if (!in_xfer) begin
        exp_g = rr_pick(m_last, v_before);
        check("grant_id", 64'(grant_id), 64'(exp_g));
        g = (exp_g < N) ? exp_g : 0;
        m_last    = g;
        in_xfer   = 1'b1;
        pen_cnt   = 0;
        setup_cnt = 1;
        g_write   = req_write[g];
        g_addr    = req_addr[g*AW +: AW];
        g_wdata   = req_wdata[g*DW +: DW];
        check("setup_paddr", 64'(PADDR), 64'(g_addr));
        check("setup_pwrite", 64'(PWRITE), 64'(g_write));
        check("setup_busy", 64'(busy), 64'd1);
        wait_n = $urandom_range(max_wait, min_wait);
      end else begin
        setup_cnt++;
      end
    end else if (PSEL && PENABLE && in_xfer) begin
      pen_cnt++;
      check("access_paddr", 64'(PADDR), 64'(g_addr));
      check("access_pwrite", 64'(PWRITE), 64'(g_write));
      if (g_write) check("access_pwdata", 64'(PWDATA), 64'(g_wdata));
    end
    if (rsp_done != '0) begin
      check("done_onehot", 64'(rsp_done), in_xfer ? (64'd1 << g) : 64'd0);
      exp_err = stuck || (g_addr >= MEMSIZE);
      if (stuck) m_rdata = '0;
      else if (!g_write) m_rdata = (g_addr < MEMSIZE) ? ref_mem[g_addr[5:0]] : '0;
      if (g_write && !exp_err) ref_mem[g_addr[5:0]] = g_wdata;
      check("rsp_err", 64'(rsp_err), 64'(exp_err));
      check("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
      check("busy_in_done", 64'(busy), 64'd0);
      check("psel_in_done", 64'(PSEL), 64'd0);
      check("access_len", 64'(pen_cnt), stuck ? 64'(TMO) : 64'(wait_n + 1));
      check("setup_len", 64'(setup_cnt), 64'd1);
      in_xfer = 1'b0;
      n_done++;
    end
  endtask

  task automatic run_until_done(input int budget);
    for (int c = 0; c < budget; c++) begin
      tick();
      if (done_seen != '0) break;
    end
    check("done_within_budget", 64'(done_seen != '0), 64'd1);
  endtask

  task automatic do_reset();
    PRESETn   = 1'b0;
    req_valid = '0;
    in_xfer   = 1'b0;
    m_last    = N - 1;
    m_rdata   = '0;
    stuck     = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned order [5];
    int unsigned n_got;

    // Reset state.
    @(posedge PCLK);
    #1;
    check("rst_psel", 64'(PSEL), 64'd0);
    check("rst_penable", 64'(PENABLE), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(rsp_done), 64'd0);
    check("rst_grant", 64'(grant_id), 64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_err", 64'(rsp_err), 64'd0);
    PRESETn = 1'b1;

    // Zero-wait write: SETUP, ACCESS, done on consecutive cycles.
    post(0, 1'b1, 32'h05, 32'hA5);
    tick();
    check("t1_psel_c1", 64'(PSEL), 64'd1);
    check("t1_penable_c1", 64'(PENABLE), 64'd0);
    tick();
    check("t1_penable_c2", 64'(PENABLE), 64'd1);
    tick();
    check("t1_done_c3", 64'(rsp_done), 64'b0001);
    req_valid[0] = 1'b0;
    tick();
    check("t1_done_pulse", 64'(rsp_done), 64'd0);
    check("t1_sram5", 64'(mem[5]), 64'hA5);

    // Read back.
    post(0, 1'b0, 32'h05, 32'h0);
    run_until_done(20);
    check("t2_rdata", 64'(rsp_rdata), 64'hA5);
    req_valid[0] = 1'b0;
    tick();

    // All four requesting continuously: strict rotation from requester 0.
    do_reset();
    for (int unsigned i = 0; i < N; i++) post(i, 1'b1, 32'(8 + i), $urandom);
    n_got = 0;
    for (int c = 0; c < 60 && n_got < 5; c++) begin
      tick();
      if (done_seen != '0) begin
        order[n_got] = 32'(grant_id);
        n_got++;
        post(32'(grant_id), 1'b1, 32'(8 + grant_id), $urandom);
      end
    end
    req_valid = '0;
    check("t3_count", 64'(n_got), 64'd5);
    for (int k = 0; k < 5; k++) check("t3_order", 64'(order[k]), 64'(k % N));
    tick();

    // Out-of-range write reports an error to requester 2 only.
    post(2, 1'b1, 32'h40, 32'h1234);
    run_until_done(20);
    check("t4_done", 64'(done_seen), 64'b0100);
    check("t4_err", 64'(rsp_err), 64'd1);
    req_valid[2] = 1'b0;
    tick();

    // Three wait states: PENABLE high for four cycles.
    min_wait = 3;
    max_wait = 3;
    post(3, 1'b1, 32'h10, 32'hCAFE);
    run_until_done(20);
    check("t5_penable_cycles", 64'(pen_cnt), 64'd4);
    req_valid[3] = 1'b0;
    tick();

    // Reset during ACCESS abandons the transfer with no done pulse.
    min_wait = 5;
    max_wait = 5;
    post(1, 1'b0, 32'h03, 32'h0);
    for (int c = 0; c < 10; c++) begin
      tick();
      if (PSEL && PENABLE) break;
    end
    check("t6_in_access", 64'(PENABLE), 64'd1);
    PRESETn = 1'b0;
    #1;
    check("t6_psel_rst", 64'(PSEL), 64'd0);
    check("t6_penable_rst", 64'(PENABLE), 64'd0);
    check("t6_busy_rst", 64'(busy), 64'd0);
    req_valid = '0;
    in_xfer   = 1'b0;
    m_last    = N - 1;
    m_rdata   = '0;
    repeat (2) tick();
    PRESETn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("t6_no_done", 64'(done_seen), 64'd0);
    end

`ifdef APB_ARB_TIMEOUT_EN
    // Stuck slave: watchdog aborts after TMO ACCESS cycles.
    stuck = 1'b1;
    post(1, 1'b0, 32'h03, 32'h0);
    run_until_done(40);
    check("t6_tmo_err", 64'(rsp_err), 64'd1);
    check("t6_tmo_len", 64'(pen_cnt), 64'(TMO));
    check("t6_tmo_rdata", 64'(rsp_rdata), 64'd0);
    req_valid[1] = 1'b0;
    stuck = 1'b0;
    tick();
`endif

    // Random traffic with random wait states, address errors and post-grant request changes.
    min_wait = 0;
    max_wait = 3;
    n_done   = 0;
    for (int c = 0; c < 800; c++) begin
      tick();
      for (int unsigned i = 0; i < N; i++) if (done_seen[i]) req_valid[i] = 1'b0;
      if (in_xfer && $urandom_range(0, 3) == 0) begin
        req_write[g] = ~req_write[g];
        req_addr[g*AW +: AW]  = $urandom;
        req_wdata[g*DW +: DW] = $urandom;
      end
      for (int unsigned i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 4) == 0)
          post(i, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 79)), $urandom);
    end
    for (int c = 0; c < 40; c++) begin
      tick();
      for (int unsigned i = 0; i < N; i++) if (done_seen[i]) req_valid[i] = 1'b0;
      req_valid = req_valid & ~done_seen;
      if (!in_xfer) req_valid = '0;
    end
    check("rand_progress", 64'(n_done > 60), 64'd1);
    check("rand_drained", 64'(in_xfer), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
